noobs_dmem_bridge: RTL and testbench
====================================

NOOBS_DMEM_BRIDGE -- requirements
Module: noobs_dmem_bridge

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 16, clk cycles per UART bit (legal 2..255).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, UART TX FIFO entries (power of two).
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- m_addr  in  12  CPU data address.
- m_wr_data  in  8  CPU write data.
- m_rd_data  out  8  read data to CPU.
- m_en  in  1  CPU access enable.
- m_rd  in  1  CPU read strobe.
- m_wr  in  1  CPU write strobe.
- ram_addr  out  12  synchronous RAM address.
- ram_wr_data  out  8  RAM write data.
- ram_rd_data  in  8  RAM read data, valid one cycle after ram_en.
- ram_en  out  1  RAM enable.
- ram_wr  out  1  RAM write enable.
- gpio_out  out  8  GPIO output register.
- gpio_in  in  8  asynchronous GPIO inputs.
- uart_tx  out  1  8N1 serial output, idle high.

Function
REQ-004 Address map: 0x000-0xEFF RAM; 0xF00 GPIO_OUT rw; 0xF01 GPIO_IN ro; 0xF02 UART_DATA wo; 0xF03 STATUS; 0xF04 TMR_LO; 0xF05 TMR_HI; 0xF06-0xFFF unmapped.
REQ-005 Access valid only when m_en=1 and exactly one of m_rd/m_wr is 1; m_rd=m_wr=1 performs no access and sets STATUS.err.
REQ-006 RAM region: ram_en=m_en&valid, ram_wr=m_wr, ram_addr=m_addr, ram_wr_data=m_wr_data, all combinational; ram_en=0 for MMIO/invalid.
REQ-007 Read latency exactly one cycle: region flag and MMIO read value registered at the request edge; m_rd_data = RAM region ? ram_rd_data : registered MMIO value.
REQ-008 m_rd_data holds its last value in cycles following no read.
REQ-009 Unmapped or write-only reads return 0x00; writes to read-only/unmapped addresses are ignored.
REQ-010 gpio_in passes through a 2-flop synchronizer; GPIO_IN read returns synchronized value.
REQ-011 STATUS bits: [0] fifo_full, [1] fifo_empty, [2] tx_busy, [3] ovf sticky, [4] err sticky, [7:5] 0; write with bit3/bit4 =1 clears that sticky bit; other bits ignored.
REQ-012 Timer: 16-bit free-running counter, +1 each cycle, wraps 0xFFFF->0x0000.
REQ-013 TMR_LO read returns counter[7:0] and latches counter[15:8] same edge; TMR_HI read returns the latch; any write to TMR_LO clears counter to 0 next cycle.
REQ-014 UART_DATA write pushes byte when FIFO not full; when full byte is dropped and ovf set, judged on count before any same-cycle pop.
REQ-015 Simultaneous push and pop with FIFO not full: both occur, count unchanged.
REQ-016 Serializer FSM IDLE->START->DATA->STOP->IDLE; IDLE with FIFO non-empty pops head and enters START on same edge.
REQ-017 START drives 0, DATA drives bits LSB first, STOP drives 1; each bit lasts CLK_DIV cycles; IDLE drives 1.
REQ-018 IDLE lasts at least one cycle between frames; frame-to-frame period 10*CLK_DIV+1 cycles.
REQ-019 tx_busy=1 in any state other than IDLE.

Reset
REQ-020 While reset=1: gpio_out=0x00, uart_tx=1, m_rd_data=0x00, timer=0, latch=0, FIFO empty, ovf=err=0, FSM IDLE, synchronizers 0.
REQ-021 Reset mid-frame aborts transmission; uart_tx returns high asynchronously; FIFO contents discarded.

Structure
REQ-022 Shared package noobs_io_pkg SHALL hold address constants, STATUS bit indices, UART FSM state encoding.
REQ-023 FIFO plus serializer SHALL be one sub-module noobs_uart_tx; decode, GPIO, timer, read mux remain in top.

Verification
REQ-024 Write 0xA5 to 0x123, read 0x123 -> ram_wr pulse, m_rd_data=0xA5 one cycle after read.
REQ-025 Write 0x3C to 0xF00, read 0xF00 -> gpio_out=0x3C, read returns 0x3C; gpio_in=0x81 -> GPIO_IN reads 0x81 within 3 cycles.
REQ-026 Push 0x55 with CLK_DIV=16 -> uart_tx low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high; tx_busy 160 cycles.
REQ-027 Push 6 bytes back-to-back with FIFO_DEPTH=4 idle serializer -> 5 accepted (one popped immediately), 6th dropped, STATUS=0x0D; write 0x08 to 0xF03 -> ovf clears.
REQ-028 Counter=0x12FF, read TMR_LO then TMR_HI two cycles later -> 0xFF then 0x12; write TMR_LO -> next read near 0x00.
REQ-029 m_en=m_rd=m_wr=1 -> no RAM/MMIO effect, STATUS.err=1; reset asserted mid-frame -> uart_tx=1 immediately, STATUS=0x02 after release.

Source files
------------

// File: rtl/noobs_io_pkg.sv
// Shared definitions for the data-memory bridge: MMIO address map,
// STATUS bit positions and the UART serializer state encoding.
package noobs_io_pkg;

  localparam logic [11:0] ADDR_MMIO_BASE = 12'hF00;
  localparam logic [11:0] ADDR_GPIO_OUT  = 12'hF00;
  localparam logic [11:0] ADDR_GPIO_IN   = 12'hF01;
  localparam logic [11:0] ADDR_UART_DATA = 12'hF02;
  localparam logic [11:0] ADDR_STATUS    = 12'hF03;
  localparam logic [11:0] ADDR_TMR_LO    = 12'hF04;
  localparam logic [11:0] ADDR_TMR_HI    = 12'hF05;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_ERR   = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/noobs_uart_tx.sv
// UART transmit path: small byte FIFO feeding an 8N1 serializer.
// The serializer pops the FIFO head on the same edge it leaves IDLE.
module noobs_uart_tx
  import noobs_io_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_req,
  input  logic [7:0] push_data,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       tx_busy,
  output logic       ovf_pulse,
  output logic       uart_tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  tx_state_e        state_q, state_d;
  logic [7:0]       baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;

  logic push, pop, baud_done;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  // Fullness is judged on the count before any pop in the same cycle.
  assign push       = push_req & ~fifo_full;
  assign ovf_pulse  = push_req & fifo_full;
  assign tx_busy    = (state_q != TX_IDLE);
  assign baud_done  = (baud_q == DIV_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level decoded from state so reset forces it high without a clock.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = shreg_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/noobs_dmem_bridge.sv
// CPU data-port bridge: routes accesses to synchronous RAM or to the MMIO
// block (GPIO, status, free-running timer, UART transmitter).
module noobs_dmem_bridge
  import noobs_io_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] m_addr,
  input  logic [7:0]  m_wr_data,
  output logic [7:0]  m_rd_data,
  input  logic        m_en,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wr_data,
  input  logic [7:0]  ram_rd_data,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [7:0]  gpio_out,
  input  logic [7:0]  gpio_in,
  output logic        uart_tx
);

  logic acc_vld, is_ram, rd_vld, wr_vld, both_err, status_wr, uart_push;
  logic fifo_full, fifo_empty, tx_busy, ovf_pulse;
  logic [7:0] status, mmio_rd_val;

  logic [7:0]  gpio_out_q, gpio_out_d;
  logic [7:0]  gpio_s1_q, gpio_s1_d;
  logic [7:0]  gpio_s2_q, gpio_s2_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  tmr_hi_q, tmr_hi_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  rd_data_q, rd_data_d;

  assign acc_vld   = m_en & (m_rd ^ m_wr);
  assign both_err  = m_en & m_rd & m_wr;
  assign is_ram    = (m_addr < ADDR_MMIO_BASE);
  assign rd_vld    = acc_vld & m_rd;
  assign wr_vld    = acc_vld & m_wr;
  assign status_wr = wr_vld & (m_addr == ADDR_STATUS);
  assign uart_push = wr_vld & (m_addr == ADDR_UART_DATA);

  assign ram_en      = acc_vld & is_ram;
  assign ram_wr      = ram_en & m_wr;
  assign ram_addr    = m_addr;
  assign ram_wr_data = m_wr_data;

  assign gpio_out = gpio_out_q;
  assign status   = {3'b000, err_q, ovf_q, tx_busy, fifo_empty, fifo_full};

  // RAM data is passed straight through in the response cycle, then held.
  assign m_rd_data = rd_pend_q ? ram_rd_data : rd_data_q;

  always_comb begin
    mmio_rd_val = 8'h00;
    case (m_addr)
      ADDR_GPIO_OUT: mmio_rd_val = gpio_out_q;
      ADDR_GPIO_IN:  mmio_rd_val = gpio_s2_q;
      ADDR_STATUS:   mmio_rd_val = status;
      ADDR_TMR_LO:   mmio_rd_val = tmr_q[7:0];
      ADDR_TMR_HI:   mmio_rd_val = tmr_hi_q;
      default:       mmio_rd_val = 8'h00;
    endcase
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    gpio_s1_d  = gpio_in;
    gpio_s2_d  = gpio_s1_q;
    tmr_d      = tmr_q + 16'd1;
    tmr_hi_d   = tmr_hi_q;
    ovf_d      = ovf_q | ovf_pulse;
    err_d      = err_q | both_err;
    rd_pend_d  = rd_vld & is_ram;
    rd_data_d  = rd_data_q;

    if (wr_vld && m_addr == ADDR_GPIO_OUT) gpio_out_d = m_wr_data;
    if (wr_vld && m_addr == ADDR_TMR_LO)   tmr_d      = 16'h0000;
    if (rd_vld && m_addr == ADDR_TMR_LO)   tmr_hi_d   = tmr_q[15:8];
    if (status_wr && m_wr_data[ST_OVF])    ovf_d      = 1'b0;
    if (status_wr && m_wr_data[ST_ERR])    err_d      = 1'b0;

    if (rd_pend_q)          rd_data_d = ram_rd_data;
    if (rd_vld && !is_ram)  rd_data_d = mmio_rd_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_q <= 8'h00;
      gpio_s1_q  <= 8'h00;
      gpio_s2_q  <= 8'h00;
      tmr_q      <= 16'h0000;
      tmr_hi_q   <= 8'h00;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_s1_d;
      gpio_s2_q  <= gpio_s2_d;
      tmr_q      <= tmr_d;
      tmr_hi_q   <= tmr_hi_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      rd_pend_q  <= rd_pend_d;
      rd_data_q  <= rd_data_d;
    end
  end

  noobs_uart_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_uart_tx (
    .clk       (clk),
    .reset     (reset),
    .push_req  (uart_push),
    .push_data (m_wr_data),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .tx_busy   (tx_busy),
    .ovf_pulse (ovf_pulse),
    .uart_tx   (uart_tx)
  );

endmodule

// File: tb/tb_noobs_dmem_bridge.sv
// Scoreboard bench for noobs_dmem_bridge: reads and UART frames are queued
// when issued and checked by independent monitor processes.
module tb_noobs_dmem_bridge;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] m_addr = '0;
  logic [7:0]  m_wr_data = '0;
  logic [7:0]  m_rd_data;
  logic        m_en = 1'b0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_rd_data;
  logic        ram_en;
  logic        ram_wr;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in = 8'h00;
  logic        uart_tx;

  noobs_dmem_bridge #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_en(m_en), .m_rd(m_rd), .m_wr(m_wr),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
    .ram_en(ram_en), .ram_wr(ram_wr), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, write-through on writes.
  logic [7:0] ram_mem [4096];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        ram_mem[ram_addr] <= ram_wr_data;
        ram_rd_data       <= ram_wr_data;
      end else begin
        ram_rd_data <= ram_mem[ram_addr];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  exp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] uart_q[$];

  // Read monitor: a read sampled on a rising edge is answered in the next cycle.
  logic rd_vld_tb;
  always @(posedge clk or posedge reset) begin
    if (reset) rd_vld_tb <= 1'b0;
    else       rd_vld_tb <= m_en & m_rd & ~m_wr;
  end

  always @(negedge clk) begin : mon_rd
    rd_exp_t e;
    if (rd_vld_tb) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 16'd1, 16'd0);
      end else begin
        e = rd_q.pop_front();
        check($sformatf("rd[%03h]", e.addr), {8'h00, m_rd_data}, {8'h00, e.exp});
      end
    end
  end

  // UART monitor: samples each bit at its first, middle and last cycle.
  initial begin : mon_uart
    logic prev, abort, bad, s0, sm, sl;
    logic [7:0] rcv;
    int idx;
    prev = 1'b1;
    s0 = 1'b1;
    sm = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !uart_tx) begin
        abort = 1'b0;
        bad   = 1'b0;
        rcv   = 8'h00;
        for (int i = 0; i < 10 * CLK_DIV; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          idx = i / CLK_DIV;
          if (i % CLK_DIV == 0) s0 = uart_tx;
          else if (i % CLK_DIV == CLK_DIV / 2) sm = uart_tx;
          if (i % CLK_DIV == CLK_DIV - 1) begin
            sl = uart_tx;
            if (s0 !== sm || sm !== sl) bad = 1'b1;
            if (idx == 0 && sm !== 1'b0) bad = 1'b1;
            if (idx == 9 && sm !== 1'b1) bad = 1'b1;
            if (idx >= 1 && idx <= 8) rcv[idx-1] = sm;
          end
        end
        if (abort) begin
          while (reset) @(negedge clk);
        end else begin
          check("uart_bit_timing", {15'd0, bad}, 16'd0);
          if (uart_q.size() == 0) check("uart_unexpected_frame", {8'h00, rcv}, 16'hFFFF);
          else check("uart_byte", {8'h00, rcv}, {8'h00, uart_q.pop_front()});
        end
      end
      prev = reset ? 1'b1 : uart_tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    m_en = 1'b0;
    m_rd = 1'b0;
    m_wr = 1'b0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_bus();
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    m_en = 1'b1; m_wr = 1'b1; m_rd = 1'b0;
    m_addr = a; m_wr_data = d;
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] e);
    @(negedge clk);
    m_en = 1'b1; m_rd = 1'b1; m_wr = 1'b0;
    m_addr = a;
    rd_q.push_back('{addr: a, exp: e});
  endtask

  task automatic both(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    m_en = 1'b1; m_rd = 1'b1; m_wr = 1'b1;
    m_addr = a; m_wr_data = d;
  endtask

  initial begin : stim
    idle_bus();
    nop(3);
    check("rst_gpio_out", {8'h00, gpio_out}, 16'h0000);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    check("rst_m_rd_data", {8'h00, m_rd_data}, 16'h0000);
    check("rst_ram_en", {15'd0, ram_en}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset MMIO state and unmapped / write-only reads
    rd(12'hF03, 8'h02);
    rd(12'hF05, 8'h00);
    rd(12'hF01, 8'h00);
    rd(12'hF02, 8'h00);
    rd(12'hF10, 8'h00);
    rd(12'hFFF, 8'h00);

    // RAM write/read and read-data hold
    wr(12'h123, 8'hA5);
    #1;
    check("ram_wr_pulse", {14'd0, ram_en, ram_wr}, 16'h0003);
    check("ram_addr", {4'h0, ram_addr}, 16'h0123);
    check("ram_wr_data", {8'h00, ram_wr_data}, 16'h00A5);
    rd(12'h123, 8'hA5);
    nop(2);
    check("hold_after_ram_rd", {8'h00, m_rd_data}, 16'h00A5);
    wr(12'h124, 8'h77);
    nop(1);
    check("hold_across_ram_wr", {8'h00, m_rd_data}, 16'h00A5);
    rd(12'h124, 8'h77);
    wr(12'hEFF, 8'h11);
    #1;
    check("ram_en_top", {15'd0, ram_en}, 16'd1);
    rd(12'hEFF, 8'h11);

    // GPIO
    wr(12'hF00, 8'h3C);
    #1;
    check("ram_en_mmio", {15'd0, ram_en}, 16'd0);
    nop(1);
    check("gpio_out", {8'h00, gpio_out}, 16'h003C);
    rd(12'hF00, 8'h3C);
    wr(12'hF01, 8'hFF);
    nop(1);
    gpio_in = 8'h81;
    nop(1);
    rd(12'hF01, 8'h81);

    // Read and write together: no access, sticky err
    both(12'h123, 8'h00);
    #1;
    check("both_ram_en", {14'd0, ram_en, ram_wr}, 16'd0);
    both(12'hF00, 8'h00);
    nop(1);
    check("both_gpio_kept", {8'h00, gpio_out}, 16'h003C);
    rd(12'h123, 8'hA5);
    rd(12'hF03, 8'h12);
    wr(12'hF03, 8'h10);
    rd(12'hF03, 8'h02);
    nop(2);

    // Single frame 0x55 and tx_busy window
    uart_q.push_back(8'h55);
    wr(12'hF02, 8'h55);
    rd(12'hF03, 8'h00);
    nop(159);
    rd(12'hF03, 8'h06);
    rd(12'hF03, 8'h02);
    nop(2);

    // FIFO overflow: 5 accepted, 6th dropped
    uart_q.push_back(8'h01);
    uart_q.push_back(8'h80);
    uart_q.push_back(8'hC3);
    uart_q.push_back(8'h7E);
    uart_q.push_back(8'h99);
    wr(12'hF02, 8'h01);
    wr(12'hF02, 8'h80);
    wr(12'hF02, 8'hC3);
    wr(12'hF02, 8'h7E);
    wr(12'hF02, 8'h99);
    wr(12'hF02, 8'hEE);
    rd(12'hF03, 8'h0D);
    wr(12'hF03, 8'h08);
    rd(12'hF03, 8'h05);
    nop(5 * (10 * CLK_DIV + 1) + 20);
    rd(12'hF03, 8'h02);

    // Timer latch at 0x12FF and clear
    wr(12'hF04, 8'h00);
    nop(16'h12FF);
    rd(12'hF04, 8'hFF);
    nop(1);
    rd(12'hF05, 8'h12);
    nop(2);
    check("hold_after_mmio_rd", {8'h00, m_rd_data}, 16'h0012);
    wr(12'hF04, 8'h55);
    rd(12'hF04, 8'h00);
    rd(12'hF05, 8'h00);

    // Reset in the middle of a frame
    wr(12'hF02, 8'h81);
    wr(12'hF02, 8'h22);
    nop(40);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_uart_tx", {15'd0, uart_tx}, 16'd1);
    @(negedge clk);
    check("rst_mid_gpio_out", {8'h00, gpio_out}, 16'h0000);
    check("rst_mid_m_rd_data", {8'h00, m_rd_data}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    rd(12'hF03, 8'h02);
    rd(12'hF00, 8'h00);
    nop(12 * CLK_DIV);

    check("rd_q_drained", rd_q.size(), 16'd0);
    check("uart_q_drained", uart_q.size(), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
